// File: rtl/sha1_pkg.sv
// Shared sizes and the feeder state encoding for the sha1 block feeder.
package sha1_pkg;
    localparam int BLOCK_BITS      = 512;
    localparam int WORD_BITS       = 32;
    localparam int WORDS_PER_BLOCK = 16;
    localparam int HASH_BITS       = 160;
    localparam int CNT_W           = $clog2(BLOCK_BITS / 8 + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_START,
        ST_RUN,
        ST_WAIT_DONE,
        ST_ERR
    } feeder_state_e;
endpackage

// File: rtl/sha1_block_buf.sv
// One 512-bit block assembler; the bypass outputs include a word written this cycle.
module sha1_block_buf
    import sha1_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [WORD_BITS-1:0]  wr_data,
    input  logic                  wr_last,
    input  logic [2:0]            wr_bytes,
    output logic                  ready,
    output logic                  byp_ready,
    output logic [BLOCK_BITS-1:0] byp_block,
    output logic [CNT_W-1:0]      byp_count
);
    logic [BLOCK_BITS-1:0] data;
    logic [3:0]            idx;
    logic [CNT_W-1:0]      cnt;
    logic                  rdy;
    logic                  wr_ok;
    logic [CNT_W-1:0]      word_bytes;
    logic [8:0]            base;

    assign wr_ok = wr_en && !rdy;
    assign ready = rdy;
    // Word k lands at bit (15-k)*32, i.e. the inverted index shifted by 5.
    assign base  = {~idx, 5'd0};

    always_comb begin
        word_bytes = CNT_W'(4);
        if (wr_last) begin
            word_bytes = (wr_bytes > 3'd4) ? CNT_W'(4) : CNT_W'(wr_bytes);
        end
        byp_block = data;
        byp_count = cnt;
        byp_ready = rdy;
        if (wr_ok) begin
            byp_block[base +: WORD_BITS] = wr_data;
            byp_count = cnt + word_bytes;
            byp_ready = wr_last || (idx == 4'(WORDS_PER_BLOCK - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            data <= '0;
            idx  <= '0;
            cnt  <= '0;
            rdy  <= 1'b0;
        end else if (wr_ok) begin
            data <= byp_block;
            idx  <= idx + 4'd1;
            cnt  <= byp_count;
            rdy  <= byp_ready;
        end
    end
endmodule

// File: rtl/sha1_feeder.sv
// Streams a word-wide message into ping-pong block buffers and sequences one sha1 core.
module sha1_feeder
    import sha1_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_BITS-1:0]  in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    input  logic [2:0]            in_bytes,
    output logic                  in_ready,
    output logic                  core_start,
    output logic                  core_eof,
    output logic [BLOCK_BITS-1:0] core_data_block,
    output logic [LEN_W-1:0]      core_msg_length,
    input  logic                  core_next_block,
    input  logic                  core_done,
    input  logic [HASH_BITS-1:0]  core_hash,
    output logic [HASH_BITS-1:0]  digest,
    output logic                  digest_valid,
    output logic                  busy,
    output logic                  err,
    output logic [2:0]            dbg_state
);
    feeder_state_e state, next_state;

    logic                  wr_sel, rd_sel, last_seen;
    logic                  accept, swap, end_blk, capture, go_err;
    logic [1:0]            buf_wr, buf_clr, buf_ready, buf_byp_ready;
    logic [BLOCK_BITS-1:0] buf_byp_block [2];
    logic [CNT_W-1:0]      buf_byp_count [2];
    logic                  cand_ready;
    logic [BLOCK_BITS-1:0] cand_block;
    logic [CNT_W-1:0]      cand_count;

    // Handshake: a word transfers on a rising clk edge where in_valid && in_ready;
    // in_ready never depends on in_valid, and in_data/in_last/in_bytes are only
    // meaningful while in_valid is high.
    assign accept = in_valid && in_ready;

    always_comb begin
        in_ready = 1'b0;
        if (state inside {ST_IDLE, ST_FILL, ST_START, ST_RUN}) begin
            in_ready = !buf_ready[wr_sel] && !last_seen;
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_buf
        assign buf_wr[i]  = accept && (wr_sel == 1'(i));
        assign buf_clr[i] = capture || (swap && (rd_sel == 1'(i)));
        sha1_block_buf u_buf (
            .clk       (clk),
            .rst       (rst),
            .clear     (buf_clr[i]),
            .wr_en     (buf_wr[i]),
            .wr_data   (in_data),
            .wr_last   (in_last),
            .wr_bytes  (in_bytes),
            .ready     (buf_ready[i]),
            .byp_ready (buf_byp_ready[i]),
            .byp_block (buf_byp_block[i]),
            .byp_count (buf_byp_count[i])
        );
    end

    // The oldest ready buffer is always rd_sel; its bypass view covers a word completing it now.
    assign cand_ready = buf_byp_ready[rd_sel];
    assign cand_block = buf_byp_block[rd_sel];
    assign cand_count = buf_byp_count[rd_sel];

    always_comb begin
        next_state = state;
        swap       = 1'b0;
        end_blk    = 1'b0;
        capture    = 1'b0;
        go_err     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    swap       = cand_ready;
                    next_state = cand_ready ? ST_START : ST_FILL;
                end
            end
            ST_FILL: begin
                if (cand_ready) begin
                    swap       = 1'b1;
                    next_state = ST_START;
                end
            end
            ST_START: next_state = ST_RUN;
            ST_RUN: begin
                if (core_done) begin
                    capture    = 1'b1;
                    next_state = ST_IDLE;
                end else if (core_next_block) begin
                    if (cand_ready) begin
                        swap = 1'b1;
                    end else if (last_seen) begin
                        end_blk    = 1'b1;
                        next_state = ST_WAIT_DONE;
                    end else begin
                        go_err     = 1'b1;
                        next_state = ST_ERR;
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (core_done) begin
                    capture    = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_ERR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            wr_sel          <= 1'b0;
            rd_sel          <= 1'b0;
            last_seen       <= 1'b0;
            core_data_block <= '0;
            core_msg_length <= '0;
            core_eof        <= 1'b0;
            digest          <= '0;
            digest_valid    <= 1'b0;
            err             <= 1'b0;
        end else begin
            state        <= next_state;
            digest_valid <= capture;
            if (go_err) err <= 1'b1;
            if (capture) begin
                digest          <= core_hash;
                wr_sel          <= 1'b0;
                rd_sel          <= 1'b0;
                last_seen       <= 1'b0;
                core_data_block <= '0;
                core_msg_length <= '0;
                core_eof        <= 1'b0;
            end else begin
                if (accept && in_last) last_seen <= 1'b1;
                if (accept && buf_byp_ready[wr_sel]) wr_sel <= ~wr_sel;
                if (swap) begin
                    rd_sel          <= ~rd_sel;
                    core_data_block <= cand_block;
                    core_msg_length <= core_msg_length + LEN_W'(cand_count);
                    // Only the very first block of an empty message carries eof.
                    core_eof        <= (state != ST_RUN) && (cand_count == '0);
                end else if (end_blk) begin
                    core_data_block <= '0;
                    core_eof        <= 1'b1;
                end
            end
        end
    end

    assign core_start = (state == ST_START);
    assign busy       = (state != ST_IDLE);
    assign dbg_state  = state;
endmodule

// File: tb/tb_sha1_feeder.sv
// Directed bench for sha1_feeder; the bench plays the part of the sha1 core.
module tb_sha1_feeder;
    import sha1_pkg::*;

    localparam int LEN_W = 64;
    localparam logic [159:0] ABC_HASH   = 160'ha9993e364706816aba3e25717850c26c9cd0d89d;
    localparam logic [159:0] EMPTY_HASH = 160'hda39a3ee5e6b4b0d3255bfef95601890afd80709;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  in_data;
    logic         in_valid, in_last, in_ready;
    logic [2:0]   in_bytes;
    logic         core_start, core_eof, core_next_block, core_done;
    logic [511:0] core_data_block;
    logic [LEN_W-1:0] core_msg_length;
    logic [159:0] core_hash, digest;
    logic         digest_valid, busy, err;
    logic [2:0]   dbg_state;

    sha1_feeder #(.LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_bytes(in_bytes),
        .in_ready(in_ready),
        .core_start(core_start), .core_eof(core_eof), .core_data_block(core_data_block),
        .core_msg_length(core_msg_length), .core_next_block(core_next_block),
        .core_done(core_done), .core_hash(core_hash),
        .digest(digest), .digest_valid(digest_valid), .busy(busy), .err(err),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got still running, expected finish");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int               n_vec  = 0;
    int               n_miss = 0;
    logic [LEN_W-1:0] exp_q[$];
    logic [31:0]      msg [32];

    int               start_cnt = 0;
    logic [LEN_W-1:0] start_len;
    logic             start_eof;
    logic [511:0]     start_blk;

    always @(negedge clk) begin
        if (core_start) begin
            start_cnt++;
            start_len = core_msg_length;
            start_eof = core_eof;
            start_blk = core_data_block;
        end
    end

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_len(input string tag, input logic [LEN_W-1:0] got);
        if (exp_q.size() == 0) check({tag, "_q_empty"}, 512'(exp_q.size()), 512'd1);
        else check(tag, got, exp_q.pop_front());
    endtask

    function automatic logic [511:0] blk_of(input int first, input int n);
        logic [511:0] b = '0;
        for (int k = 0; k < n; k++) b[511 - 32*k -: 32] = msg[first + k];
        return b;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_msg(input int nwords, input bit with_last, input logic [2:0] last_bytes,
                            output int stalls);
        int guard;
        stalls = 0;
        for (int i = 0; i < nwords; i++) begin
            in_data  = msg[i];
            in_last  = with_last && (i == nwords - 1);
            in_bytes = in_last ? last_bytes : 3'd0;
            in_valid = 1'b1;
            guard    = 0;
            while (!in_ready && guard < 50) begin
                tick();
                stalls++;
                guard++;
            end
            if (!in_ready) begin
                check("send_ready_timeout", in_ready, 1);
                break;
            end
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_bytes = 3'd0;
    endtask

    task automatic request(input string tag, input logic exp_eof, input logic [511:0] exp_blk);
        core_next_block = 1'b1;
        tick();
        core_next_block = 1'b0;
        check({tag, "_eof"}, core_eof, exp_eof);
        check({tag, "_blk"}, core_data_block, exp_blk);
        check_len({tag, "_len"}, core_msg_length);
    endtask

    task automatic finish_msg(input string tag, input logic [159:0] hash);
        core_hash = hash;
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        check({tag, "_dvalid"}, digest_valid, 1);
        check({tag, "_digest"}, digest, hash);
        check({tag, "_idle"}, busy, 0);
        tick();
        check({tag, "_dvalid_clr"}, digest_valid, 0);
        check({tag, "_digest_hold"}, digest, hash);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int st, sc0;
        rst = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0; in_bytes = 3'd0;
        core_next_block = 1'b0; core_done = 1'b0; core_hash = '0;
        tick(); tick();
        check("rst_start", core_start, 0);
        check("rst_eof", core_eof, 0);
        check("rst_blk", core_data_block, 0);
        check("rst_len", core_msg_length, 0);
        check("rst_digest", digest, 0);
        check("rst_dvalid", digest_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_state", dbg_state, 0);
        rst = 1'b0;
        tick();
        check("idle_in_ready", in_ready, 1);

        // "abc": single partial block, eof on the following request
        msg[0] = 32'h61626300;
        sc0 = start_cnt;
        exp_q.push_back(64'd3);
        send_msg(1, 1'b1, 3'd3, st);
        check("abc_start_latency", core_start, 1);
        check("abc_in_ready_low", in_ready, 0);
        tick();
        check("abc_start_one_cycle", core_start, 0);
        check("abc_start_cnt", start_cnt, sc0 + 1);
        check("abc_start_eof", start_eof, 0);
        check("abc_start_blk", start_blk, {32'h61626300, 480'h0});
        check_len("abc_start_len", start_len);
        exp_q.push_back(64'd3);
        request("abc_req", 1'b1, '0);
        finish_msg("abc", ABC_HASH);

        // empty message: eof on the start block itself
        msg[0] = 32'h0;
        exp_q.push_back(64'd0);
        send_msg(1, 1'b1, 3'd0, st);
        tick();
        check("empty_start_eof", start_eof, 1);
        check_len("empty_start_len", start_len);
        finish_msg("empty", EMPTY_HASH);

        // two words, in_bytes above 4 counts as 4
        msg[0] = 32'h11223344;
        msg[1] = 32'h55667788;
        exp_q.push_back(64'd8);
        send_msg(2, 1'b1, 3'd7, st);
        tick();
        check("w2_start_blk", start_blk, blk_of(0, 2));
        check_len("w2_start_len", start_len);
        exp_q.push_back(64'd8);
        request("w2_req", 1'b1, '0);
        finish_msg("w2", 160'h0123456789abcdef0123456789abcdef01234567);

        // exactly 64 bytes
        for (int k = 0; k < 16; k++) msg[k] = 32'h01010101 * (k + 1);
        exp_q.push_back(64'd64);
        send_msg(16, 1'b1, 3'd4, st);
        tick();
        check("b64_start_eof", start_eof, 0);
        check("b64_start_blk", start_blk, blk_of(0, 16));
        check_len("b64_start_len", start_len);
        exp_q.push_back(64'd64);
        request("b64_req", 1'b1, '0);
        finish_msg("b64", 160'hfedcba9876543210fedcba9876543210fedcba98);

        // 100 bytes streamed back-to-back
        for (int k = 0; k < 25; k++) msg[k] = 32'ha0000000 + k;
        exp_q.push_back(64'd64);
        send_msg(25, 1'b1, 3'd4, st);
        check("b100_stalls", st, 0);
        check("b100_in_ready_low", in_ready, 0);
        tick();
        check("b100_start_blk", start_blk, blk_of(0, 16));
        check_len("b100_start_len", start_len);
        exp_q.push_back(64'd100);
        request("b100_req1", 1'b0, blk_of(16, 9));
        exp_q.push_back(64'd100);
        request("b100_req2", 1'b1, '0);
        finish_msg("b100", 160'h13579bdf02468ace13579bdf02468ace13579bdf);

        // underrun: full block without in_last, then a request with nothing pending
        for (int k = 0; k < 16; k++) msg[k] = 32'hc0de0000 + k;
        exp_q.push_back(64'd64);
        send_msg(16, 1'b0, 3'd0, st);
        tick();
        check_len("urun_start_len", start_len);
        core_next_block = 1'b1;
        tick();
        core_next_block = 1'b0;
        check("urun_err", err, 1);
        check("urun_in_ready", in_ready, 0);
        check("urun_state", dbg_state, 3'(ST_ERR));
        in_valid = 1'b1; in_data = 32'hdeadbeef;
        core_done = 1'b1; core_hash = ABC_HASH;
        tick(); tick(); tick();
        check("urun_in_ready_held", in_ready, 0);
        check("urun_err_sticky", err, 1);
        check("urun_done_ignored", digest_valid, 0);
        in_valid = 1'b0; core_done = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("urun_rst_err", err, 0);
        check("urun_rst_in_ready", in_ready, 1);

        // rst while RUN, then a clean "abc"
        msg[0] = 32'h61626300;
        exp_q.push_back(64'd3);
        send_msg(1, 1'b1, 3'd3, st);
        tick();
        check_len("rrun_start_len", start_len);
        finish_msg("rrun_pre", 160'h1);
        msg[0] = 32'h61626300;
        exp_q.push_back(64'd3);
        send_msg(1, 1'b1, 3'd3, st);
        tick();
        check_len("rrun2_start_len", start_len);
        rst = 1'b1;
        tick();
        check("rrun_start", core_start, 0);
        check("rrun_eof", core_eof, 0);
        check("rrun_blk", core_data_block, 0);
        check("rrun_len", core_msg_length, 0);
        check("rrun_digest", digest, 0);
        check("rrun_dvalid", digest_valid, 0);
        check("rrun_busy", busy, 0);
        check("rrun_err", err, 0);
        rst = 1'b0;
        tick();
        exp_q.push_back(64'd3);
        send_msg(1, 1'b1, 3'd3, st);
        check("rabc_start", core_start, 1);
        tick();
        check_len("rabc_start_len", start_len);
        exp_q.push_back(64'd3);
        request("rabc_req", 1'b1, '0);
        finish_msg("rabc", ABC_HASH);

        check("exp_q_drained", 512'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
